expr_gen: RTL and testbench

- Generates a random, grammatically valid arithmetic expression as an ASCII character stream, one character per cycle.
- Grammar: `digit (op digit)*`, where op is `+` or `*`.
- Serves as the stimulus source paired with the expression recognizer, driving its 8-bit `in` directly.
- Optionally injects a grammar error at the end of the stream, so benches can check both accept and reject paths.

---
 rtl/expr_pkg.sv | 29 ++
 rtl/expr_lfsr.sv | 20 ++
 rtl/expr_gen.sv | 112 +++++++++++
 tb/tb_expr_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared definitions for the expression generator: ASCII codes, FSM states,
// LFSR taps and character helpers.
package expr_pkg;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;

  // Feedback taps l[7], l[5], l[4], l[3]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    OP    = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] digit_char(input logic [7:0] l);
    logic [3:0] d;
    d = (l[3:0] > 4'd9) ? (l[3:0] - 4'd10) : l[3:0];
    return CH_ZERO + {4'h0, d};
  endfunction

  function automatic logic [7:0] op_char(input logic [7:0] l);
    return l[4] ? CH_MUL : CH_PLUS;
  endfunction

endpackage

// File: rtl/expr_lfsr.sv
// 8-bit Fibonacci LFSR: reloads SEED on load, advances one step when step is high.
module expr_lfsr
  import expr_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       load,
  input  logic       step,
  output logic [7:0] value
);

  always_ff @(posedge clk) begin
    if (load)
      value <= SEED;
    else if (step)
      value <= {value[6:0], ^(value & LFSR_TAPS)};
  end

endmodule

// File: rtl/expr_gen.sv
// Random "digit (op digit)*" ASCII stream generator, one character per cycle.
// Defining GEN_ERR_EN adds inject_err, which turns the last digit into '+'.
module expr_gen
  import expr_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [3:0] n_terms,
`ifdef GEN_ERR_EN
  input  logic       inject_err,
`endif
  output logic [7:0] out,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  state_t     state, state_d;
  logic [3:0] terms, terms_d;
  logic [3:0] count, count_d;
  logic       err_q, err_d, err_in;
  logic [7:0] lfsr;
  logic [7:0] out_d;
  logic       valid_d, busy_d, done_d;

`ifdef GEN_ERR_EN
  assign err_in = inject_err;
`else
  assign err_in = 1'b0;
`endif

  expr_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .load  (clr),
    .step  (valid_d),
    .value (lfsr)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      terms <= 4'd1;
      count <= '0;
      err_q <= 1'b0;
      out   <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      terms <= terms_d;
      count <= count_d;
      err_q <= err_d;
      out   <= out_d;
      valid <= valid_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // count holds the index of the next digit to emit; it advances when leaving DIGIT.
  always_comb begin
    state_d = state;
    terms_d = terms;
    count_d = count;
    err_d   = err_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = DIGIT;
          terms_d = (n_terms == 4'd0) ? 4'd1 : n_terms;
          count_d = '0;
          err_d   = err_in;
        end
      end
      DIGIT: begin
        if (count == terms - 4'd1) begin
          state_d = DONE;
        end else begin
          state_d = OP;
          count_d = count + 4'd1;
        end
      end
      OP:      state_d = DIGIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    out_d   = '0;
    valid_d = 1'b0;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    unique case (state_d)
      DIGIT: begin
        valid_d = 1'b1;
        out_d   = (err_d && (count_d == terms_d - 4'd1)) ? CH_PLUS : digit_char(lfsr);
      end
      OP: begin
        valid_d = 1'b1;
        out_d   = op_char(lfsr);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_expr_gen.sv
// Self-checking bench for expr_gen: directed scenarios plus randomized
// expressions compared against a character-level reference model.
module tb_expr_gen;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [3:0] n_terms;
`ifdef GEN_ERR_EN
  logic       inject_err;
`endif
  logic [7:0] out;
  logic       valid, busy, done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_l;
  logic [7:0] got[$];

  always #5 clk = ~clk;

  expr_gen #(.SEED(8'hA5)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .n_terms (n_terms),
`ifdef GEN_ERR_EN
    .inject_err (inject_err),
`endif
    .out     (out),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_out"},   out,   8'h00);
    chk({tag, "_valid"}, {7'b0, valid}, 8'h00);
    chk({tag, "_busy"},  {7'b0, busy},  8'h00);
    chk({tag, "_done"},  {7'b0, done},  8'h00);
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [7:0] char_of(input logic [7:0] l, input bit is_digit);
    int d;
    if (is_digit) begin
      d = int'(l) % 16;
      if (d > 9) d = d - 10;
      return 8'(48 + d);
    end
    return l[4] ? 8'h2A : 8'h2B;
  endfunction

  // Grammar digit (op digit)*
  function automatic bit accepts();
    if (got.size() % 2 == 0) return 1'b0;
    foreach (got[i]) begin
      if (i % 2 == 0) begin
        if (got[i] < 8'h30 || got[i] > 8'h39) return 1'b0;
      end else begin
        if (got[i] != 8'h2A && got[i] != 8'h2B) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    m_l = 8'hA5;
  endtask

  task automatic run_expr(input int nt, input bit err, input bit poke);
    int t;
    int len;
    logic [7:0] e;
    t   = (nt == 0) ? 1 : nt;
    len = 2 * t - 1;
    got.delete();
    n_terms = 4'(nt);
    start   = 1'b1;
`ifdef GEN_ERR_EN
    inject_err = err;
`endif
    @(posedge clk); #1;
    start   = 1'b0;
    n_terms = 4'($urandom);
`ifdef GEN_ERR_EN
    inject_err = ~err;
`endif
    for (int k = 0; k < len; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      e = char_of(m_l, (k % 2) == 0);
      if (err && k == len - 1) e = 8'h2B;
      m_l = lfsr_next(m_l);
      chk("char",     out,           e);
      chk("valid",    {7'b0, valid}, 8'h01);
      chk("busy",     {7'b0, busy},  8'h01);
      chk("done_low", {7'b0, done},  8'h00);
      got.push_back(out);
      if (poke && k == 1) start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse", {7'b0, done},  8'h01);
    chk("done_valid", {7'b0, valid}, 8'h00);
    chk("done_out",   out,           8'h00);
    chk("done_busy",  {7'b0, busy},  8'h01);
    @(posedge clk); #1;
    check_idle("after_done");
  endtask

  initial begin
    clr     = 1'b1;
    start   = 1'b0;
    n_terms = 4'd0;
`ifdef GEN_ERR_EN
    inject_err = 1'b0;
`endif
    m_l = 8'hA5;
    @(posedge clk); #1;
    do_clr();
    check_idle("reset");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_idle("idle");
    end

    // Known stream from SEED
    run_expr(2, 1'b0, 1'b0);
    chk("seed_c0", got[0], 8'h35);
    chk("seed_c1", got[1], 8'h2B);
    chk("seed_c2", got[2], 8'h35);

    // n_terms = 0 gives one digit
    run_expr(0, 1'b0, 1'b0);
    chk("one_len", 8'(got.size()), 8'd1);
    chk("one_digit", {7'b0, got[0] >= 8'h30 && got[0] <= 8'h39}, 8'h01);

    // Longest stream, grammar-checked
    run_expr(15, 1'b0, 1'b1);
    chk("long_len", 8'(got.size()), 8'd29);
    chk("long_accept", {7'b0, accepts()}, 8'h01);

    // Mid-stream start ignored, then clr on the 3rd character of a 5-term stream
    n_terms = 4'd5;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      chk("abort_char",  out,           char_of(m_l, (k % 2) == 0));
      chk("abort_valid", {7'b0, valid}, 8'h01);
      m_l = lfsr_next(m_l);
      if (k == 1) start = 1'b1;
    end
    do_clr();
    check_idle("post_clr");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_idle("no_done");
    end
    run_expr(2, 1'b0, 1'b0);
    chk("restart_c0", got[0], 8'h35);
    chk("restart_c1", got[1], 8'h2B);
    chk("restart_c2", got[2], 8'h35);

    // Randomized expressions; LFSR continues across them
    for (int r = 0; r < 10; r++) begin
      run_expr(int'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)));
      chk("rand_accept", {7'b0, accepts()}, 8'h01);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        @(posedge clk); #1;
        check_idle("gap");
      end
    end

`ifdef GEN_ERR_EN
    do_clr();
    run_expr(2, 1'b1, 1'b0);
    chk("err_c0", got[0], 8'h35);
    chk("err_c1", got[1], 8'h2B);
    chk("err_c2", got[2], 8'h2B);
    chk("err_reject", {7'b0, accepts()}, 8'h00);
    run_expr(3, 1'b0, 1'b0);
    chk("err_off_accept", {7'b0, accepts()}, 8'h01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
